// File: rtl/recirc_shift_bank_if.sv
// Bus between the character-write/display-timing side (master) and the recirculating shift bank (slave).
// clr_req/clr_busy exist only when RSR_SWEEP_CLEAR_EN is defined.
interface recirc_shift_bank_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 40
);
  localparam int PW = $clog2(DEPTH);

  logic             shift_en;
  logic             rc;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    pos;
  logic             wrap;
`ifdef RSR_SWEEP_CLEAR_EN
  logic             clr_req;
  logic             clr_busy;

  modport master (output shift_en, rc, in, clr_req, input out, pos, wrap, clr_busy);
  modport slave  (input shift_en, rc, in, clr_req, output out, pos, wrap, clr_busy);
`else
  modport master (output shift_en, rc, in, input out, pos, wrap);
  modport slave  (input shift_en, rc, in, output out, pos, wrap);
`endif
endinterface

// File: rtl/recirc_shift_bank.sv
// WIDTH-lane x DEPTH-stage recirculating shift bank; a word entering stage 0 reaches out DEPTH shifts later, all state holds while shift_en=0.
// Optional clear sweep (writes CLEAR_VAL into DEPTH consecutive shifts) is built only with RSR_SWEEP_CLEAR_EN.
module recirc_shift_bank #(
  parameter int               WIDTH     = 6,
  parameter int               DEPTH     = 40,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(6'h20)
) (
  input logic                clk,
  input logic                rst,
  recirc_shift_bank_if.slave bus
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] feed;
  logic [PW-1:0]    pos_q;
  logic             wrap_q;

`ifdef RSR_SWEEP_CLEAR_EN
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state;
  logic [PW-1:0] swp_cnt;
  logic          busy_q;

  // A request seen in IDLE only arms the sweep; the first cleared word goes in on the next shifting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      swp_cnt <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state   <= SWEEP;
            busy_q  <= 1'b1;
            swp_cnt <= '0;
          end
        end
        SWEEP: begin
          if (bus.shift_en) begin
            if (swp_cnt == LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              swp_cnt <= swp_cnt + PW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.clr_busy = busy_q;
`endif

  always_comb begin
    feed = bus.rc ? bus.in : stage[DEPTH-1];
`ifdef RSR_SWEEP_CLEAR_EN
    if (state == SWEEP) feed = CLEAR_VAL;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.shift_en) begin
        stage[0] <= feed;
        for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        pos_q  <= (pos_q == LAST) ? '0 : pos_q + PW'(1);
        wrap_q <= (pos_q == LAST);
      end
    end
  end

  assign bus.out  = stage[DEPTH-1];
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;
endmodule

// File: doc/recirc_shift_bank.md
Name: recirc_shift_bank

Overview:
- Parametrised recirculating shift-register bank: WIDTH parallel lanes, each DEPTH stages deep. Generalises the fixed hex 40-bit dynamic shift register used as video character memory.
- Adds the following over the fixed part:
  - async reset
  - shift enable
  - a position counter with wrap pulse
  - optional hardware clear sweep
- Sits between the terminal's character-write path and the video character generator. Display timing drives shift_en.

Parameters:
- WIDTH, 6, bits per word (lane count); legal 1..32.
- DEPTH, 40, words stored (stages per lane); legal 2..1024.
- CLEAR_VAL, 6'h20, word written by the clear sweep; WIDTH bits wide; only used with RSR_SWEEP_CLEAR_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- shift_en  in  1  1 = advance every lane one stage this edge; 0 = hold all state.
- rc  in  1  1 = load in[] into stage 0 on a shift; 0 = recirculate out[] into stage 0.
- in  in  WIDTH  write data, sampled on a shifting edge when rc=1.
- out  out  WIDTH  oldest word (stage DEPTH-1), combinational from storage.
- pos  out  $clog2(DEPTH)  index of the word currently at out, counted in shifts since reset, modulo DEPTH.
- wrap  out  1  one-cycle pulse, high in the cycle after a shift that moved pos from DEPTH-1 to 0.
- clr_req  in  1  (RSR_SWEEP_CLEAR_EN only) start a clear sweep.
- clr_busy  out  1  (RSR_SWEEP_CLEAR_EN only) sweep in progress.

Behaviour:
- Reset (async, wins over everything):
  - All storage 0, so out=0.
  - pos=0, wrap=0, clr_busy=0, sweep FSM in IDLE.
  - An operation interrupted mid-shift is abandoned; there is no partial state.
- Shifting edge (shift_en=1):
  - Each lane shifts by one stage, stage[k] <= stage[k-1].
  - stage[0] <= in when rc=1, otherwise the pre-edge out (recirculate).
  - pos <= (pos==DEPTH-1) ? 0 : pos+1.
  - wrap <= (pos==DEPTH-1).
- Non-shifting edge (shift_en=0):
  - Storage and pos hold; rc and in are ignored.
  - wrap <= 0.
- Latency: a word written on shift edge N appears at out after edge N+DEPTH-1, i.e. DEPTH shifts after entry.
- With rc held 0, content is lossless indefinitely: after every DEPTH shifts, out reproduces the same sequence.
- pos arithmetic:
  - Unsigned, wraps exactly at DEPTH; DEPTH need not be a power of 2.
  - pos never reaches DEPTH.
- Out is a pure function of storage; it never depends on the inputs in the same cycle.

Optional Feature:
- Macro: RSR_SWEEP_CLEAR_EN.
- With the macro defined, the clr_req/clr_busy ports and the sweep FSM exist:
  - FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: when clr_req=1. This sets clr_busy=1 and loads a sweep counter with 0.
  - In SWEEP, each shifting edge writes CLEAR_VAL into stage 0, overriding rc and in, and increments the sweep counter.
  - SWEEP -> IDLE: on the shifting edge where the sweep counter reaches DEPTH-1, i.e. exactly DEPTH words cleared; clr_busy then drops.
  - Edges with shift_en=0 do not advance the sweep.
  - clr_req while busy is ignored.
  - clr_req coinciding with a shifting edge in IDLE: that edge uses normal rc/in; the sweep starts on the next shifting edge.
  - pos and wrap run normally during a sweep.
- Without the macro: the ports are absent, stage 0 is fed only per rc, and there is no added logic.

Test Plan:
- Reset: assert rst mid-stream with a nonzero pattern loaded -> out=0, pos=0, wrap=0 immediately, without waiting for clk.
- Load/readback, defaults: rc=1 for 40 shifts writing 0..39, then rc=0 -> out=0 after the last load edge; out shows 0..39 repeating across 80 further shifts; pos matches the word value.
- Hold: 40 words loaded, shift_en=0 for 100 cycles -> out and pos unchanged, wrap=0 throughout.
- Wrap/non-power-of-2 DEPTH: DEPTH=5, WIDTH=3, continuous shift -> pos sequence 0,1,2,3,4,0; wrap high for exactly one cycle after each 4->0 shift.
- Gated shifting: rc=1, shift_en toggling 1/0 -> words are written only on enabled edges; after 40 enabled shifts the first word appears at out.
- Clear sweep (macro on): load 0x15 everywhere, pulse clr_req, shift continuously -> clr_busy high for exactly 40 shifting edges; a second clr_req mid-sweep is ignored; afterwards all 40 words read back 0x20.
